// File: rtl/issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : issue_ctrl_if
// Brief    : Fetch/execute <-> issue controller signal bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface issue_ctrl_if;
    logic        inst_valid;
    logic [31:0] inst;
    logic        br_resolve;
    logic        br_taken;
    logic        pc_en;
    logic        pc_load;
    logic        stall;
    logic        issue_valid;
    logic [31:0] issue_inst;
    logic        br_err;
    logic [15:0] stall_cnt;

    // Fetch/execute side.
    modport master (
        output inst_valid, inst, br_resolve, br_taken,
        input  pc_en, pc_load, stall, issue_valid, issue_inst, br_err, stall_cnt
    );

    // Issue controller side.
    modport slave (
        input  inst_valid, inst, br_resolve, br_taken,
        output pc_en, pc_load, stall, issue_valid, issue_inst, br_err, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : issue_ctrl
// Brief    : In-order issue controller with countdown scoreboard and branch
//            serialisation. Optional macro ISSUE_FWD_EN selects forwarding
//            latencies (ALU writers untracked, loads tracked for 2 cycles).
// Revision : 1.0 - initial release
// ============================================================================
module issue_ctrl #(
    parameter int ALU_LAT    = 3,
    parameter int LOAD_LAT   = 4,
    parameter int BR_TIMEOUT = 16
) (
    input  wire logic   clk,
    input  wire logic   rst,
    issue_ctrl_if.slave bus
);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_BR_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] c_br_timeout = 8'(BR_TIMEOUT);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q [64];
    logic [2:0]  cnt_d [64];
    logic [7:0]  tmo_q, tmo_d;
    logic        issue_valid_q, issue_valid_d;
    logic [31:0] issue_inst_q, issue_inst_d;
    logic        br_err_q, br_err_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic [3:0]  w_op;
    logic [5:0]  w_rd, w_r1, w_r2;
    logic        w_is_br, w_is_load, w_writes;
    logic        w_hazard, w_issue;
    logic        w_set_en;
    logic [2:0]  w_set_val;
    logic        w_pc_en, w_pc_load, w_stall;
    logic [9:0]  w_unused_bits;

    assign w_op          = bus.inst[31:28];
    assign w_rd          = bus.inst[27:22];
    assign w_r1          = bus.inst[21:16];
    assign w_r2          = bus.inst[15:10];
    assign w_unused_bits = bus.inst[9:0];

    assign w_is_br   = (w_op == 4'b1000) || (w_op == 4'b1001) || (w_op == 4'b1011);
    assign w_is_load = (w_op == 4'b1110);
    assign w_writes  = !((w_op == 4'b0000) || (w_op == 4'b0011) || w_is_br);

`ifdef ISSUE_FWD_EN
    // Forwarding covers ALU results entirely; loads still need one bubble.
    assign w_set_en  = w_writes && w_is_load;
    assign w_set_val = 3'd2;
`else
    localparam logic [2:0] c_alu_lat  = 3'(ALU_LAT);
    localparam logic [2:0] c_load_lat = 3'(LOAD_LAT);
    assign w_set_en  = w_writes;
    assign w_set_val = w_is_load ? c_load_lat : c_alu_lat;
`endif

    // A count of 1 is written back this cycle and read write-first, so no hazard.
    assign w_hazard = bus.inst_valid && ((cnt_q[w_r1] > 3'd1) || (cnt_q[w_r2] > 3'd1));

    always_comb begin
        state_d       = state_q;
        tmo_d         = tmo_q;
        issue_valid_d = 1'b0;
        issue_inst_d  = 32'd0;
        br_err_d      = br_err_q;
        stall_cnt_d   = stall_cnt_q;
        w_pc_en       = 1'b0;
        w_pc_load     = 1'b0;
        w_stall       = 1'b0;
        w_issue       = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.inst_valid) begin
                    if (w_hazard) begin
                        w_stall     = 1'b1;
                        stall_cnt_d = (stall_cnt_q == 16'hFFFF) ? stall_cnt_q
                                                                : stall_cnt_q + 16'd1;
                    end else begin
                        w_issue       = 1'b1;
                        issue_valid_d = 1'b1;
                        issue_inst_d  = bus.inst;
                        if (w_is_br) begin
                            state_d = ST_BR_WAIT;
                            tmo_d   = c_br_timeout;
                        end else begin
                            w_pc_en = 1'b1;
                        end
                    end
                end
            end
            ST_BR_WAIT: begin
                if (bus.br_resolve) begin
                    w_pc_en   = 1'b1;
                    w_pc_load = bus.br_taken;
                    state_d   = ST_RUN;
                end else if (tmo_q <= 8'd1) begin
                    // Counter would hit zero this cycle: give up and fall through.
                    br_err_d = 1'b1;
                    w_pc_en  = 1'b1;
                    tmo_d    = 8'd0;
                    state_d  = ST_RUN;
                end else begin
                    tmo_d = tmo_q - 8'd1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Scoreboard: decrement every live counter; a new writer overrides.
    always_comb begin
        for (int i = 0; i < 64; i++) begin
            cnt_d[i] = (cnt_q[i] != 3'd0) ? cnt_q[i] - 3'd1 : 3'd0;
        end
        if (w_issue && w_set_en) begin
            cnt_d[w_rd] = w_set_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            tmo_q         <= 8'd0;
            issue_valid_q <= 1'b0;
            issue_inst_q  <= 32'd0;
            br_err_q      <= 1'b0;
            stall_cnt_q   <= 16'd0;
            for (int i = 0; i < 64; i++) begin
                cnt_q[i] <= 3'd0;
            end
        end else begin
            state_q       <= state_d;
            tmo_q         <= tmo_d;
            issue_valid_q <= issue_valid_d;
            issue_inst_q  <= issue_inst_d;
            br_err_q      <= br_err_d;
            stall_cnt_q   <= stall_cnt_d;
            for (int i = 0; i < 64; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // PC controls are suppressed during reset so no update happens on that edge.
    assign bus.pc_en       = w_pc_en & ~rst;
    assign bus.pc_load     = w_pc_load & ~rst;
    assign bus.stall       = w_stall & ~rst;
    assign bus.issue_valid = issue_valid_q;
    assign bus.issue_inst  = issue_inst_q;
    assign bus.br_err      = br_err_q;
    assign bus.stall_cnt   = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_issue_ctrl
// Brief    : Scoreboard bench for issue_ctrl, default latencies (3/4/16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_issue_ctrl;

    typedef struct {
        logic [31:0] inst;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic [15:0] exp_sc;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    issue_ctrl_if bus ();

    issue_ctrl #(
        .ALU_LAT   (3),
        .LOAD_LAT  (4),
        .BR_TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [31:0] ins,
                         input logic res, input logic tk);
        @(negedge clk);
        rst            = r;
        bus.inst_valid = v;
        bus.inst       = ins;
        bus.br_resolve = res;
        bus.br_taken   = tk;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic expect_issue(input logic [31:0] ins, input int at);
        exp_t e;
        e.inst = ins;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    task automatic add_stalls(input int n);
        for (int i = 0; i < n; i++) begin
            if (exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
        end
    endtask

    // Producer then immediately dependent consumer, expecting nstall stalls.
    task automatic dep_pair(input logic [31:0] prod, input logic [31:0] cons,
                            input int nstall, input string tag);
        drive(1'b0, 1'b1, prod, 1'b0, 1'b0);
        chk({tag, "_prod_pc_en"}, 32'(bus.pc_en), 32'd1);
        chk({tag, "_prod_stall"}, 32'(bus.stall), 32'd0);
        expect_issue(prod, cyc + 1);
        for (int i = 0; i < nstall; i++) begin
            drive(1'b0, 1'b1, cons, 1'b0, 1'b0);
            chk({tag, "_stall"}, 32'(bus.stall), 32'd1);
            chk({tag, "_stall_pc_en"}, 32'(bus.pc_en), 32'd0);
        end
        drive(1'b0, 1'b1, cons, 1'b0, 1'b0);
        chk({tag, "_cons_stall"}, 32'(bus.stall), 32'd0);
        chk({tag, "_cons_pc_en"}, 32'(bus.pc_en), 32'd1);
        chk({tag, "_cons_pc_load"}, 32'(bus.pc_load), 32'd0);
        expect_issue(cons, cyc + 1);
        add_stalls(nstall);
        idle(1);
        chk({tag, "_stall_cnt"}, 32'(bus.stall_cnt), 32'(exp_sc));
    endtask

    // Monitor: every real instruction in IF/ID must match the next expected one.
    always @(negedge clk) begin
        if (bus.issue_valid === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL issue_unexpected: got %h at cycle %0d expected none",
                         bus.issue_inst, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (bus.issue_inst !== mon_e.inst || cyc != mon_e.cyc) begin
                    bad++;
                    $display("FAIL issue_stream: got %h at cycle %0d expected %h at cycle %0d",
                             bus.issue_inst, cyc, mon_e.inst, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        bus.inst_valid = 1'b0;
        bus.inst       = 32'd0;
        bus.br_resolve = 1'b0;
        bus.br_taken   = 1'b0;
        exp_sc         = 16'd0;

        // Reset: combinational outputs gated even with an issuable instruction.
        drive(1'b1, 1'b1, 32'h41410800, 1'b0, 1'b0);
        chk("rst_pc_en", 32'(bus.pc_en), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        drive(1'b1, 1'b1, 32'h41850000, 1'b1, 1'b1);
        chk("rst_pc_load", 32'(bus.pc_load), 32'd0);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
        chk("rst_issue_inst", bus.issue_inst, 32'd0);
        chk("rst_br_err", 32'(bus.br_err), 32'd0);
        chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);

        // ALU producer r5 -> consumer reading r5: 2 stalls.
        dep_pair(32'h41410800, 32'h41850000, 2, "alu");
        idle(6);

        // Load r7 -> consumer reading r7: 3 stalls, cumulative count 5.
        dep_pair(32'hE1C00000, 32'h42070000, 3, "load");
        idle(8);

        // Branch resolved taken 3 cycles after issue: 3 bubbles then redirect.
        drive(1'b0, 1'b1, 32'h80030000, 1'b0, 1'b0);
        chk("br_issue_pc_en", 32'(bus.pc_en), 32'd0);
        chk("br_issue_stall", 32'(bus.stall), 32'd0);
        expect_issue(32'h80030000, cyc + 1);
        for (int k = 1; k <= 3; k++) begin
            drive(1'b0, 1'b1, 32'h41410800, (k == 3), 1'b1);
            chk("br_wait_stall", 32'(bus.stall), 32'd0);
            chk("br_wait_pc_en", 32'(bus.pc_en), (k == 3) ? 32'd1 : 32'd0);
            chk("br_wait_pc_load", 32'(bus.pc_load), (k == 3) ? 32'd1 : 32'd0);
            if (k > 1) chk("br_bubble", 32'(bus.issue_valid), 32'd0);
        end
        drive(1'b0, 1'b1, 32'h30000000, 1'b0, 1'b0);
        chk("br_after_pc_en", 32'(bus.pc_en), 32'd1);
        chk("br_after_pc_load", 32'(bus.pc_load), 32'd0);
        chk("br_bubble3", 32'(bus.issue_valid), 32'd0);
        expect_issue(32'h30000000, cyc + 1);
        idle(2);
        chk("br_stall_cnt", 32'(bus.stall_cnt), 32'(exp_sc));

        // Branch never resolved: forced exit after 16 BR_WAIT cycles.
        drive(1'b0, 1'b1, 32'h90000000, 1'b0, 1'b0);
        chk("to_issue_pc_en", 32'(bus.pc_en), 32'd0);
        expect_issue(32'h90000000, cyc + 1);
        for (int k = 1; k <= 16; k++) begin
            drive(1'b0, 1'b1, 32'h41410800, 1'b0, 1'b0);
            chk("to_pc_en", 32'(bus.pc_en), (k == 16) ? 32'd1 : 32'd0);
            chk("to_pc_load", 32'(bus.pc_load), 32'd0);
            chk("to_br_err_early", 32'(bus.br_err), 32'd0);
        end
        // br_resolve while in RUN has no effect.
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        chk("to_br_err", 32'(bus.br_err), 32'd1);
        chk("run_resolve_pc_en", 32'(bus.pc_en), 32'd0);
        chk("run_resolve_pc_load", 32'(bus.pc_load), 32'd0);
        idle(3);
        chk("to_br_err_sticky", 32'(bus.br_err), 32'd1);
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("to_br_err_cleared", 32'(bus.br_err), 32'd0);
        chk("to_stall_cnt_cleared", 32'(bus.stall_cnt), 32'd0);
        exp_sc = 16'd0;

        // Reset during the second stall cycle of the ALU pair.
        drive(1'b0, 1'b1, 32'h41410800, 1'b0, 1'b0);
        chk("rs_prod_pc_en", 32'(bus.pc_en), 32'd1);
        expect_issue(32'h41410800, cyc + 1);
        drive(1'b0, 1'b1, 32'h41850000, 1'b0, 1'b0);
        chk("rs_stall1", 32'(bus.stall), 32'd1);
        drive(1'b1, 1'b1, 32'h41850000, 1'b0, 1'b0);
        chk("rs_rst_pc_en", 32'(bus.pc_en), 32'd0);
        chk("rs_rst_stall", 32'(bus.stall), 32'd0);
        drive(1'b0, 1'b1, 32'h41850000, 1'b0, 1'b0);
        chk("rs_issue_valid", 32'(bus.issue_valid), 32'd0);
        chk("rs_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        chk("rs_no_stall", 32'(bus.stall), 32'd0);
        chk("rs_pc_en", 32'(bus.pc_en), 32'd1);
        expect_issue(32'h41850000, cyc + 1);
        idle(6);

        // Reset during BR_WAIT: no PC update on that edge, back in RUN after.
        drive(1'b0, 1'b1, 32'h80030000, 1'b0, 1'b0);
        expect_issue(32'h80030000, cyc + 1);
        drive(1'b0, 1'b1, 32'h41410800, 1'b0, 1'b0);
        chk("rb_wait_pc_en", 32'(bus.pc_en), 32'd0);
        drive(1'b1, 1'b1, 32'h41410800, 1'b1, 1'b1);
        chk("rb_rst_pc_en", 32'(bus.pc_en), 32'd0);
        chk("rb_rst_pc_load", 32'(bus.pc_load), 32'd0);
        drive(1'b0, 1'b1, 32'h30000000, 1'b0, 1'b0);
        chk("rb_run_pc_en", 32'(bus.pc_en), 32'd1);
        chk("rb_run_pc_load", 32'(bus.pc_load), 32'd0);
        expect_issue(32'h30000000, cyc + 1);
        idle(8);

        // Saturation: preload 16'hFFFE, then 3 load stalls.
        @(negedge clk);
        force dut.stall_cnt_q = 16'hFFFE;
        #1;
        release dut.stall_cnt_q;
        idle(1);
        exp_sc = 16'hFFFE;
        chk("sat_preload", 32'(bus.stall_cnt), 32'(exp_sc));
        dep_pair(32'hE1C00000, 32'h42070000, 3, "sat");
        chk("sat_value", 32'(bus.stall_cnt), 32'h0000FFFF);

        idle(4);
        chk("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/issue_ctrl.md
# issue_ctrl

In-order issue controller between instruction fetch and decode. It holds each fetched 32-bit instruction until its source registers are free, using a per-register countdown scoreboard. It serialises branches and jumps, freezing fetch until execute resolves them. It drives the PC enable/load controls and the IF/ID pipeline register, inserting bubbles on stalls.

## Interface
- `ALU_LAT`, 3, cycles from issue until an ALU result is readable from the register file (1..7).
- `LOAD_LAT`, 4, cycles from issue until a load result is readable (1..7).
- `BR_TIMEOUT`, 16, maximum cycles in BR_WAIT before a forced exit (1..255).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `inst_valid`  in  1  `inst` holds the instruction at the current PC.
- `inst`  in  32  fetched instruction: [31:28] opcode, [27:22] rd, [21:16] r1, [15:10] r2, [9:0] unused.
- `br_resolve`  in  1  one-cycle pulse from execute: the in-flight branch/jump has resolved.
- `br_taken`  in  1  qualifies `br_resolve`: redirect to the target.
- `pc_en`  out  1  combinational; PC updates this edge.
- `pc_load`  out  1  combinational; when `pc_en`=1, PC loads the target instead of PC+1.
- `stall`  out  1  combinational; a hazard is blocking issue this cycle.
- `issue_valid`  out  1  registered; IF/ID holds a real instruction.
- `issue_inst`  out  32  registered; IF/ID instruction, 0 when bubble.
- `br_err`  out  1  registered, sticky; BR_WAIT timed out.
- `stall_cnt`  out  16  registered; saturating count of stall cycles.

## Operation
- Opcode classes:
  - Branch/jump: 1000, 1001, 1011.
  - Load: 1110.
  - No rd write: 0000 (NOP), 0011 (store), and branch/jump.
  - All other opcodes are ALU ops that write rd.
- Scoreboard: 64 entries × 3-bit counters. Every cycle each nonzero counter decrements by 1.
- Issuing a writer sets `cnt[rd]` to `ALU_LAT` (ALU) or `LOAD_LAT` (load). Set wins over decrement on the same entry in the same cycle.
- Hazard: `cnt[r1]>1` or `cnt[r2]>1`, using pre-update counters. A count of 1 means write-back happens this cycle, and the register file is write-first.
- FSM states RUN and BR_WAIT; reset enters RUN.
- RUN, `inst_valid`=0:
  - bubble: `issue_valid`←0, `issue_inst`←0.
  - `pc_en`=0.
- RUN, hazard:
  - `stall`=1, `pc_en`=0, bubble.
  - `stall_cnt` increments.
- RUN, issue of a non-branch:
  - `issue_valid`←1, `issue_inst`←`inst`.
  - `pc_en`=1, `pc_load`=0.
- RUN, issue of a branch/jump:
  - issued as above, but `pc_en`=0.
  - next state BR_WAIT; timeout counter loaded with `BR_TIMEOUT`.
- BR_WAIT:
  - `pc_en`=0 and a bubble every cycle; `inst` is ignored.
  - `stall` is not asserted, and these cycles are not counted.
- BR_WAIT exit on `br_resolve`=1:
  - `pc_en`=1, `pc_load`=`br_taken`, bubble; next state RUN.
- BR_WAIT exit on timeout counter reaching 0 without `br_resolve`:
  - `br_err`←1, `pc_en`=1, `pc_load`=0; next state RUN.
- `br_resolve` in RUN is ignored.
- `pc_load`=0 whenever `pc_en`=0.
- `stall_cnt` saturates at 16'hFFFF.

## Timing
- Reset values: `issue_valid`=0, `issue_inst`=0, `br_err`=0, `stall_cnt`=0, all scoreboard counters 0, state RUN.
- Combinational outputs while `rst`=1: `pc_en`=0, `pc_load`=0, `stall`=0.
- Issue latency is 1 cycle: the instruction accepted in cycle N appears on `issue_inst` in cycle N+1.
- A dependent instruction immediately following its producer stalls LAT−1 cycles: 2 for ALU, 3 for load at the default latencies.
- A branch costs at least 1 bubble; resolve k cycles after issue gives k bubbles.
- Reset mid-BR_WAIT or mid-stall: everything returns to the reset state on that edge, and no PC update occurs in that cycle.

## Configuration
- `ISSUE_FWD_EN` defined (forwarding datapath present):
  - ALU writers do not set scoreboard entries.
  - Loads set `cnt[rd]`=2, so a dependent instruction immediately following a load stalls exactly 1 cycle.
  - `LOAD_LAT` is unused.
- Undefined: full scoreboard latencies as described under Operation.

## Test plan
- Reset then stream 0x41410800 (r5←r1,r2), 0x41850000 (r6←r5) → `stall`=1 for exactly 2 cycles, `pc_en`=0 both cycles; 0x41850000 appears on `issue_inst` on the 4th cycle after the first issue; `stall_cnt`=2.
- 0xE1C00000 (load r7), then 0x42070000 (reads r7) → 3 stall cycles; with `ISSUE_FWD_EN`, 1 stall cycle. For the ALU pair above with `ISSUE_FWD_EN`, 0 stalls.
- 0x80030000 (branch) issued, `br_resolve`=1 with `br_taken`=1 three cycles later → 3 bubbles, `pc_en`=0 throughout, then `pc_en`=1 and `pc_load`=1 for exactly one cycle, FSM back in RUN.
- Branch issued, `br_resolve` never arrives, `BR_TIMEOUT`=16 → after 16 cycles `br_err`=1 (sticky), `pc_en`=1, `pc_load`=0; a later `rst` clears `br_err`.
- `rst` asserted during the second stall cycle of the ALU pair → next cycle `issue_valid`=0, `stall_cnt`=0, scoreboard clear; re-presenting 0x41850000 issues with no stall.
- Force `stall_cnt` to 16'hFFFE, then cause 3 stall cycles → `stall_cnt` holds 16'hFFFF.
